pearson_hash_arbiter: RTL and testbench
=======================================

Name: pearson_hash_arbiter

Overview:
Shares one Pearson hash datapath (XOR stage plus external asynchronous-read 256x8 permutation table) among NUM_REQ requesters. Arbitrates round-robin and accepts a message length from the winner. Streams that requester's bytes through the h := T[h xor c] loop one byte per accepted beat, then returns the 8-bit hash tagged with the requester ID. Sits between requester clients and the permutation-table RAM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)
LEN_W, 5, width of each length field
MAX_LEN, 16, maximum message length in bytes; larger lengths are clamped
TIMEOUT, 15, byte-stall limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester start request
req_len  in  NUM_REQ*LEN_W  per-requester message length; lane i at [i*LEN_W +: LEN_W]
req_ready  out  NUM_REQ  one-hot, one-cycle pulse; grant and accept
in_data  in  NUM_REQ*8  per-requester byte lane; lane i at [i*8 +: 8]
in_valid  in  NUM_REQ  per-requester byte valid
in_ready  out  NUM_REQ  byte ready; only the granted lane may be high
tbl_addr  out  8  permutation-table read address
tbl_data  in  8  table read data; combinational (same-cycle) read
rsp_valid  out  1  hash result valid
rsp_ready  in  1  result accepted
rsp_hash  out  8  hash result
rsp_id  out  ID_W  requester that owns rsp_hash
rsp_err  out  1  result was aborted by timeout

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values:
  - state=IDLE, h=0, cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - req_ready=0, in_ready=0, rsp_valid=0, rsp_hash=0, rsp_id=0, rsp_err=0, tbl_addr=0.
- Reset asserted mid-operation aborts the transaction. No response is produced and no consumed bytes are replayed.
- FSM states: IDLE, HASH, RESP.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - Pulse req_ready[winner] for that cycle. Latch gid=winner, len=min(req_len[winner],MAX_LEN). Set h=0, cnt=0.
  - If len==0, go to RESP with hash 0. Otherwise go to HASH.
  - If no request, stay in IDLE.
- HASH:
  - in_ready[gid]=1 every cycle; all other in_ready bits are 0.
  - tbl_addr = h ^ in_data[gid].
  - When in_valid[gid] is high: h <= tbl_data, cnt <= cnt+1. If cnt==len-1, go to RESP.
  - When in_valid[gid] is low: hold h and cnt; no bubble penalty beyond the stall itself.
  - Requests on other lanes are ignored and do not preempt.
- RESP:
  - rsp_valid=1, rsp_hash=h, rsp_id=gid. All outputs are held stable while rsp_ready is low.
  - On rsp_ready: go to IDLE and set last_grant=gid. No new grant is issued in the same cycle.
- tbl_addr=0 outside HASH.
- Latency: grant cycle G; bytes at G+1 onward; rsp_valid first high at G+len+1 with zero stalls (G+1 for len==0).
- Throughput: one transaction per len+2 cycles minimum, including the RESP handshake cycle.
- h width is 8 bits. cnt width is LEN_W bits and never wraps, because len is at most MAX_LEN.

Optional Feature:
PEARSON_ARB_TIMEOUT_EN
- Defined: a stall counter in HASH increments on each cycle with in_valid[gid] low and clears on each accepted byte.
  - When it reaches TIMEOUT, the FSM goes to RESP with rsp_err=1 and rsp_hash=h (partial hash).
  - rsp_err clears when the FSM leaves RESP.
- Not defined: no stall counter exists, rsp_err is tied to 0, and HASH waits indefinitely.

Test Plan:
- Identity table T[i]=i; requester 0, len=3, bytes 0x12,0x34,0x56 with no stalls, rsp_ready=1 -> req_ready[0] pulse at cycle G; rsp_valid at G+4 with rsp_hash=0x70, rsp_id=0, rsp_err=0.
- Table T[i]=(i+1) mod 256; requester 2, len=2, bytes 0x00,0x00 -> rsp_hash=0x02, rsp_id=2.
- All four req_valid held high from reset, each with len=1 -> grant order 0,1,2,3,0; in_ready is only ever high on the granted lane.
- len=0 on requester 1 -> rsp_valid the cycle after grant, rsp_hash=0x00. Separately, req_len=31 with MAX_LEN=16 -> exactly 16 bytes consumed.
- Drop in_valid for 2 cycles mid-message and hold rsp_ready=0 for 5 cycles -> hash equals the no-stall result, and rsp_valid appears 2 cycles later. Response stays stable and no grant is issued while rsp_ready=0. Reset during HASH -> rsp_valid never rises, and the next grant goes to requester 0.
- With PEARSON_ARB_TIMEOUT_EN defined: after 1 byte, hold in_valid low for 15 cycles -> rsp_valid=1 with rsp_err=1 and rsp_hash=T[0^byte0]. Without the macro: the FSM remains in HASH and rsp_err is always 0.

Source files
------------

// File: rtl/pearson_hash_arbiter.sv
// -----------------------------------------------------------------------------
// pearson_hash_arbiter
//
// Purpose:
//   Shares one Pearson hash datapath (XOR stage plus an external, asynchronous
//   read 256x8 permutation table) among NUM_REQ requesters. An idle arbiter
//   grants round-robin, accepts the winner's message length (clamped to
//   MAX_LEN), streams that requester's bytes through h := T[h ^ c] at one byte
//   per accepted beat, and returns the 8-bit hash tagged with the requester ID.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_len   per-requester start request and length (lane i at
//                       [i*LEN_W +: LEN_W])
//   req_ready           one-hot, single-cycle grant/accept pulse
//   in_data/in_valid    per-requester byte lanes (lane i at [i*8 +: 8])
//   in_ready            byte ready, only ever high on the granted lane
//   tbl_addr/tbl_data   permutation-table read port (same-cycle read data)
//   rsp_valid/rsp_ready result handshake
//   rsp_hash/rsp_id     hash value and owning requester
//   rsp_err             result was aborted by the byte-stall timeout
//
// Optional feature macro:
//   PEARSON_ARB_TIMEOUT_EN  adds a byte-stall counter; TIMEOUT consecutive
//                           idle cycles in HASH end the message early with
//                           rsp_err=1 and the partial hash. Undefined: rsp_err
//                           is tied low and HASH waits indefinitely.
// -----------------------------------------------------------------------------
module pearson_hash_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LEN_W   = 5,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*8-1:0]     in_data,
    input  logic [NUM_REQ-1:0]       in_valid,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic [7:0]               tbl_addr,
    input  logic [7:0]               tbl_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_hash,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err
);

    // Elaboration-time sanity check of the parameter set.
    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
        MAX_LEN >= (1 << LEN_W) || TIMEOUT < 1) begin : g_bad_params
        $error("pearson_hash_arbiter: inconsistent parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        RESP = 2'd2
    } state_t;

    // Lengths above MAX_LEN are clamped rather than rejected.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_h, w_h_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic [ID_W-1:0]   r_gid, w_gid_nxt;
    logic [ID_W-1:0]   r_last, w_last_nxt;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_idx;
    logic [LEN_W-1:0]  w_win_len;
    logic [LEN_W-1:0]  w_win_len_clamped;
    logic [7:0]        w_byte;
    logic              w_byte_vld;

`ifdef PEARSON_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic               r_err, w_err_nxt;
    logic [STALL_W-1:0] r_stall, w_stall_nxt;
`endif

    // Round-robin search: first requester after last_grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Lane selection: winner's length field and the granted byte lane.
    always_comb begin
        w_win_len  = '0;
        w_byte     = '0;
        w_byte_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_win) begin
                w_win_len = req_len[i*LEN_W +: LEN_W];
            end
            if (ID_W'(i) == r_gid) begin
                w_byte     = in_data[i*8 +: 8];
                w_byte_vld = in_valid[i];
            end
        end
    end

    assign w_win_len_clamped = clamp_len(w_win_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_gid   <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
`ifdef PEARSON_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
            r_stall <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_gid   <= w_gid_nxt;
            r_last  <= w_last_nxt;
`ifdef PEARSON_ARB_TIMEOUT_EN
            r_err   <= w_err_nxt;
            r_stall <= w_stall_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_gid_nxt   = r_gid;
        w_last_nxt  = r_last;
`ifdef PEARSON_ARB_TIMEOUT_EN
        w_err_nxt   = r_err;
        w_stall_nxt = r_stall;
`endif
        req_ready   = '0;
        in_ready    = '0;
        tbl_addr    = '0;
        rsp_valid   = 1'b0;
        rsp_hash    = '0;
        rsp_id      = '0;
        rsp_err     = 1'b0;

        case (r_state)
            IDLE: begin
                // Grant is suppressed while reset is held so req_ready reads 0.
                if (w_found && !reset) begin
                    req_ready[w_win] = 1'b1;
                    w_gid_nxt        = w_win;
                    w_len_nxt        = w_win_len_clamped;
                    w_h_nxt          = '0;
                    w_cnt_nxt        = '0;
`ifdef PEARSON_ARB_TIMEOUT_EN
                    w_stall_nxt      = '0;
`endif
                    w_state_nxt      = (w_win_len_clamped == '0) ? RESP : HASH;
                end
            end

            HASH: begin
                in_ready[r_gid] = 1'b1;
                tbl_addr        = r_h ^ w_byte;
                if (w_byte_vld) begin
                    w_h_nxt   = tbl_data;
                    w_cnt_nxt = r_cnt + 1'b1;
`ifdef PEARSON_ARB_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        w_state_nxt = RESP;
                    end
                end
`ifdef PEARSON_ARB_TIMEOUT_EN
                else if (r_stall == STALL_W'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th in a row: abort.
                    w_stall_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_stall_nxt = r_stall + 1'b1;
                end
`endif
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_hash  = r_h;
                rsp_id    = r_gid;
`ifdef PEARSON_ARB_TIMEOUT_EN
                rsp_err   = r_err;
`endif
                if (rsp_ready) begin
                    w_last_nxt  = r_gid;
                    w_state_nxt = IDLE;
`ifdef PEARSON_ARB_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pearson_hash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pearson_hash_arbiter
//
// Purpose:
//   Self-checking bench for pearson_hash_arbiter. A behavioural table model
//   answers the table port; expected hashes come from the h := T[h ^ c]
//   recurrence over the bytes the bench sent, grant order from a round-robin
//   pick over the request vector.
// -----------------------------------------------------------------------------
module tb_pearson_hash_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LW   = 5;
    localparam int MAXL = 16;
    localparam int TO   = 15;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [N*8-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [7:0]        tbl_addr;
    logic [7:0]        tbl_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_hash;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;

    logic [7:0] tbl [256];
    logic [7:0] tx_bytes [16];
    logic [7:0] obs_hash;
    int         last_grant;
    int         cyc;
    int         n_checks;
    int         n_pass;
    int         n_fail;

    pearson_hash_arbiter #(
        .NUM_REQ (N),
        .ID_W    (IDW),
        .LEN_W   (LW),
        .MAX_LEN (MAXL),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hash  (rsp_hash),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    assign tbl_data = tbl[tbl_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference hash over the first len bytes of tx_bytes.
    function automatic logic [7:0] pearson(input int len);
        logic [7:0] h;
        h = 8'h00;
        for (int i = 0; i < len; i++) h = tbl[h ^ tx_bytes[i]];
        return h;
    endfunction

    // Round-robin reference: first set bit after 'last', wrapping.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic shuffle_table();
        logic [7:0] t;
        int j;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
        end
    endtask

    // One complete transaction from a single requester, starting in IDLE.
    task automatic run_txn(input int rid, input int lenf, input int stall_at,
                           input int stall_n, input int hold, input string tag);
        int         len;
        int         g;
        int         stalls;
        logic [7:0] h;
        logic [N-1:0] one;
        logic [N-1:0] other;
        len    = (lenf > MAXL) ? MAXL : lenf;
        stalls = (stall_at < len) ? stall_n : 0;
        one    = '0; one[rid] = 1'b1;
        other  = '0; other[(rid + 1) % N] = 1'b1;
        h      = 8'h00;
        req_valid = one;
        req_len   = '0;
        req_len[rid*LW +: LW] = LW'(lenf);
        @(negedge clk);
        chk({tag, ".grant"}, 32'(req_ready), 32'(one));
        g = cyc;
        step();
        req_valid = '0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    in_valid = '0;
                    @(negedge clk);
                    chk({tag, ".stall_rdy"}, 32'(in_ready), 32'(one));
                    chk({tag, ".stall_novld"}, 32'(rsp_valid), 0);
                    step();
                end
            end
            in_valid = one;
            in_data[rid*8 +: 8] = tx_bytes[i];
            @(negedge clk);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'(one));
            chk({tag, ".tbl_addr"}, 32'(tbl_addr), 32'(h ^ tx_bytes[i]));
            h = tbl[h ^ tx_bytes[i]];
            step();
        end
        in_valid  = '0;
        rsp_ready = (hold == 0);
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, ".latency"}, 32'(cyc - g), 32'(len + 1 + stalls));
        chk({tag, ".idle_in_ready"}, 32'(in_ready), 0);
        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                step();
                req_valid = other;
                @(negedge clk);
                chk({tag, ".hold_vld"}, 32'(rsp_valid), 1);
                chk({tag, ".hold_hash"}, 32'(rsp_hash), 32'(pearson(len)));
                chk({tag, ".hold_id"}, 32'(rsp_id), 32'(rid));
                chk({tag, ".hold_nogrant"}, 32'(req_ready), 0);
            end
            step();
            req_valid = '0;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".hash"}, 32'(rsp_hash), 32'(pearson(len)));
        chk({tag, ".id"}, 32'(rsp_id), 32'(rid));
        chk({tag, ".err"}, 32'(rsp_err), 0);
        obs_hash = rsp_hash;
        step();
        rsp_ready  = 1'b0;
        last_grant = rid;
    endtask

    initial begin
        int         exp_w;
        int         r_rid;
        logic [7:0] b;
        logic [7:0] ref_hash;

        n_checks = 0; n_pass = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        reset     = 1'b1;
        req_valid = '1;
        req_len   = {N{LW'(1)}};
        in_data   = '0;
        in_valid  = '0;
        rsp_ready = 1'b1;

        // Reset state while all requests are already high
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 0);
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_hash", 32'(rsp_hash), 0);
        chk("rst.rsp_id", 32'(rsp_id), 0);
        chk("rst.rsp_err", 32'(rsp_err), 0);
        chk("rst.tbl_addr", 32'(tbl_addr), 0);
        step();
        reset      = 1'b0;
        last_grant = N - 1;

        // Round-robin with every requester asking, len=1 each
        for (int g = 0; g < 5; g++) begin
            exp_w = rr_pick(last_grant, req_valid);
            @(negedge clk);
            chk("rr.grant", 32'(req_ready), 32'(1 << exp_w));
            step();
            b = 8'($urandom_range(0, 255));
            in_valid = '0; in_valid[exp_w] = 1'b1;
            in_data[exp_w*8 +: 8] = b;
            @(negedge clk);
            chk("rr.in_ready", 32'(in_ready), 32'(1 << exp_w));
            step();
            in_valid = '0;
            if (g == 4) req_valid = '0;
            @(negedge clk);
            chk("rr.rsp_valid", 32'(rsp_valid), 1);
            chk("rr.rsp_id", 32'(rsp_id), 32'(exp_w));
            chk("rr.rsp_hash", 32'(rsp_hash), 32'(tbl[b]));
            step();
            last_grant = exp_w;
        end
        rsp_ready = 1'b0;

        // Identity table, known bytes
        tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34; tx_bytes[2] = 8'h56;
        run_txn(0, 3, 99, 0, 0, "ident");
        chk("ident.const", 32'(obs_hash), 32'h70);

        // T[i] = i+1, zero bytes on requester 2
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i + 1);
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
        run_txn(2, 2, 99, 0, 0, "plus1");
        chk("plus1.const", 32'(obs_hash), 32'h02);

        // Random permutation from here on
        shuffle_table();
        fill_random();
        run_txn(1, 0, 99, 0, 0, "len0");
        chk("len0.const", 32'(obs_hash), 0);

        fill_random();
        run_txn(3, 31, 99, 0, 0, "len31");

        // Stalled message with delayed acceptance matches the unstalled hash
        fill_random();
        run_txn(0, 5, 99, 0, 0, "nostall");
        ref_hash = obs_hash;
        run_txn(0, 5, 2, 2, 5, "stall");
        chk("stall.same", 32'(obs_hash), 32'(ref_hash));

        // Randomized transactions
        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_txn(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), "rand");
        end

        // Long byte stall after the first byte
        fill_random();
        req_valid = 4'b0001;
        req_len   = '0;
        req_len[LW-1:0] = LW'(2);
        @(negedge clk);
        chk("to.grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        in_valid  = 4'b0001;
        in_data[7:0] = tx_bytes[0];
        @(negedge clk);
        chk("to.in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = '0;
`ifdef PEARSON_ARB_TIMEOUT_EN
        for (int s = 0; s < TO; s++) begin
            @(negedge clk);
            chk("to.wait_novld", 32'(rsp_valid), 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("to.rsp_valid", 32'(rsp_valid), 1);
        chk("to.rsp_err", 32'(rsp_err), 1);
        chk("to.rsp_hash", 32'(rsp_hash), 32'(tbl[tx_bytes[0]]));
        chk("to.rsp_id", 32'(rsp_id), 0);
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("to.err_clear", 32'(rsp_err), 0);
        chk("to.idle", 32'(rsp_valid), 0);
        step();
`else
        for (int s = 0; s < TO + 5; s++) begin
            @(negedge clk);
            chk("to.wait_novld", 32'(rsp_valid), 0);
            chk("to.wait_noerr", 32'(rsp_err), 0);
            chk("to.wait_rdy", 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 4'b0001;
        in_data[7:0] = tx_bytes[1];
        @(negedge clk);
        chk("to.tbl_addr", 32'(tbl_addr), 32'(tbl[tx_bytes[0]] ^ tx_bytes[1]));
        step();
        in_valid  = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("to.rsp_valid", 32'(rsp_valid), 1);
        chk("to.rsp_hash", 32'(rsp_hash), 32'(pearson(2)));
        chk("to.rsp_err", 32'(rsp_err), 0);
        step();
        rsp_ready = 1'b0;
`endif
        last_grant = 0;

        // Reset in the middle of a message on requester 2
        fill_random();
        run_txn(1, 2, 99, 0, 0, "pre_rst");
        fill_random();
        r_rid     = 2;
        req_valid = 4'b0100;
        req_len   = '0;
        req_len[r_rid*LW +: LW] = LW'(4);
        @(negedge clk);
        chk("arst.grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 4'b0100;
            in_data[r_rid*8 +: 8] = tx_bytes[i];
            @(negedge clk);
            chk("arst.in_ready", 32'(in_ready), 32'h4);
            step();
        end
        in_valid = '0;
        reset    = 1'b1;
        @(negedge clk);
        chk("arst.rsp_valid", 32'(rsp_valid), 0);
        chk("arst.in_ready0", 32'(in_ready), 0);
        chk("arst.tbl_addr", 32'(tbl_addr), 0);
        chk("arst.rsp_hash", 32'(rsp_hash), 0);
        chk("arst.rsp_id", 32'(rsp_id), 0);
        step();
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("arst.no_rsp", 32'(rsp_valid), 0);
            step();
        end
        req_valid = 4'b1101;
        req_len   = {LW'(1), LW'(1), LW'(1), LW'(0)};
        @(negedge clk);
        chk("arst.next_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("arst.len0_vld", 32'(rsp_valid), 1);
        chk("arst.len0_hash", 32'(rsp_hash), 0);
        chk("arst.len0_id", 32'(rsp_id), 0);
        step();
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
